// File: rtl/cpu_pkg.sv
// Constants shared by the control unit, datapath and instruction-fetch stage.
// Holds bus widths, opcode values and the prog_mem_fetch state encoding.
package cpu_pkg;

  localparam int CPU_AW    = 4;
  localparam int CPU_DW    = 8;
  localparam int CPU_DEPTH = 1 << CPU_AW;

  localparam logic [3:0]        OP_NOP    = 4'h0;
  localparam logic [3:0]        OP_MISC   = 4'hF;
  localparam logic [CPU_DW-1:0] HALT_WORD = 8'hF2;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/prog_mem_array.sv
// Program store: synchronous write, registered read, one port of each kind.
// The read register only updates when a read is requested, so it holds otherwise.
module prog_mem_array #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk_ctrl,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk_ctrl) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_fetch.sv
// Program memory + fetch stage: clears to NOP after reset, byte-serial loader, 1-cycle fetch.
// Define PROG_MEM_FETCH_CHECKSUM_EN to add the load_csum output.
module prog_mem_fetch
  import cpu_pkg::*;
#(
  parameter int             DEPTH    = CPU_DEPTH,
  parameter int             AW       = CPU_AW,
  parameter int             DW       = CPU_DW,
  parameter logic [DW-1:0]  CLR_WORD = 8'h00
) (
  input  logic          clk_ctrl,
  input  logic          rst_ctrl,
  input  logic [AW-1:0] pc_in,
  input  logic          fetch_req,
  output logic [DW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          busy,
  output logic          fetch_err
`ifdef PROG_MEM_FETCH_CHECKSUM_EN
  ,
  output logic [DW-1:0] load_csum
`endif
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_clr_addr;
  logic [AW:0]   r_wr_cnt;
  logic          r_have_data;
  logic          r_instr_valid;
  logic          r_load_done;
  logic [AW:0]   r_load_count;
  logic          r_fetch_err;

  logic          w_clearing;
  logic          w_load_ready;
  logic          w_load_wr;
  logic          w_fetch_ok;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  assign w_clearing   = (r_state == ST_CLEAR);
  // A byte offered in the cycle load_en drops is not accepted.
  assign w_load_ready = (r_state == ST_LOAD) && load_en && (r_wr_cnt < (AW+1)'(DEPTH));
  assign w_load_wr    = w_load_ready && load_valid;
  assign w_fetch_ok   = (r_state == ST_IDLE) && fetch_req && !load_en;

  assign w_we    = w_clearing || w_load_wr;
  assign w_waddr = w_clearing ? r_clr_addr : r_wr_cnt[AW-1:0];
  assign w_wdata = w_clearing ? CLR_WORD : load_data;

  prog_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_array (
    .clk_ctrl (clk_ctrl),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_re     (w_fetch_ok),
    .i_raddr  (pc_in),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      r_state       <= ST_CLEAR;
      r_clr_addr    <= '0;
      r_wr_cnt      <= '0;
      r_have_data   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_count  <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_instr_valid <= w_fetch_ok;
      r_fetch_err   <= fetch_req && !w_fetch_ok;
      r_load_done   <= 1'b0;
      if (w_fetch_ok) begin
        r_have_data <= 1'b1;
      end
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == AW'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (load_en) begin
            r_state  <= ST_LOAD;
            r_wr_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (!load_en) begin
            r_state      <= ST_IDLE;
            r_load_done  <= 1'b1;
            r_load_count <= r_wr_cnt;
          end else if (w_load_wr) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

`ifdef PROG_MEM_FETCH_CHECKSUM_EN
  logic [DW-1:0] r_csum;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE && load_en) begin
      r_csum <= '0;
    end else if (w_load_wr) begin
      r_csum <= r_csum + load_data;
    end
  end

  assign load_csum = r_csum;
`endif

  // The read register is not reset, so show the NOP fill until a real fetch lands.
  assign instr_out   = r_have_data ? w_rdata : CLR_WORD;
  assign instr_valid = r_instr_valid;
  assign load_ready  = w_load_ready;
  assign load_done   = r_load_done;
  assign load_count  = r_load_count;
  assign busy        = (r_state != ST_IDLE);
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Directed bench for prog_mem_fetch: clear, fetch, load sessions, overflow, abort by reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_prog_mem_fetch;

  logic       clk_ctrl = 1'b0;
  logic       rst_ctrl;
  logic [3:0] pc_in;
  logic       fetch_req;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       load_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic [4:0] load_count;
  logic       busy;
  logic       fetch_err;
`ifdef PROG_MEM_FETCH_CHECKSUM_EN
  logic [7:0] load_csum;
`endif

  int total = 0;
  int bad   = 0;

  prog_mem_fetch dut (
    .clk_ctrl    (clk_ctrl),
    .rst_ctrl    (rst_ctrl),
    .pc_in       (pc_in),
    .fetch_req   (fetch_req),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_count  (load_count),
    .busy        (busy),
    .fetch_err   (fetch_err)
`ifdef PROG_MEM_FETCH_CHECKSUM_EN
    ,
    .load_csum   (load_csum)
`endif
  );

  always #5 clk_ctrl = ~clk_ctrl;

  task automatic step();
    @(posedge clk_ctrl);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [3:0] pc, input logic [7:0] exp, input string tag);
    pc_in     = pc;
    fetch_req = 1'b1;
    step();
    chk({tag, "_valid"}, 16'(instr_valid), 16'd1);
    chk({tag, "_data"}, 16'(instr_out), 16'(exp));
    $display("fetch pc=%0d instr=%h expected=%h", pc, instr_out, exp);
    fetch_req = 1'b0;
    step();
  endtask

  task automatic clear_wait();
    for (int i = 0; i < 15; i++) step();
    chk("clear_busy_c15", 16'(busy), 16'd1);
    step();
    chk("clear_busy_c16", 16'(busy), 16'd0);
  endtask

  initial begin
    rst_ctrl   = 1'b1;
    pc_in      = '0;
    fetch_req  = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    step();
    chk("rst_busy", 16'(busy), 16'd1);
    chk("rst_instr", 16'(instr_out), 16'h00);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_ready", 16'(load_ready), 16'd0);
    chk("rst_count", 16'(load_count), 16'd0);
    chk("rst_done", 16'(load_done), 16'd0);
    chk("rst_ferr", 16'(fetch_err), 16'd0);
    step();
    rst_ctrl = 1'b0;

    // Clear cycles 1..16; a fetch at cycle 3 is refused.
    step();
    step();
    fetch_req = 1'b1;
    pc_in     = 4'd5;
    step();
    chk("clear_fetch_err", 16'(fetch_err), 16'd1);
    chk("clear_fetch_valid", 16'(instr_valid), 16'd0);
    chk("clear_fetch_instr", 16'(instr_out), 16'h00);
    $display("fetch during clear: fetch_err=%0d instr_valid=%0d", fetch_err, instr_valid);
    fetch_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("clear_busy_c15", 16'(busy), 16'd1);
    step();
    chk("clear_busy_c16", 16'(busy), 16'd0);
    do_fetch(4'd5, 8'h00, "post_clear_pc5");
    chk("valid_one_cycle", 16'(instr_valid), 16'd0);
    chk("instr_hold", 16'(instr_out), 16'h00);

    // Three-byte load session ended by load_en falling.
    load_en = 1'b1;
    step();
    chk("load3_busy", 16'(busy), 16'd1);
    chk("load3_ready", 16'(load_ready), 16'd1);
    load_valid = 1'b1; load_data = 8'h53; step();
    load_data = 8'hC1; step();
    load_data = 8'hF1; step();
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    chk("load3_done", 16'(load_done), 16'd1);
    chk("load3_count", 16'(load_count), 16'd3);
    chk("load3_idle", 16'(busy), 16'd0);
    $display("load session: done=%0d count=%0d", load_done, load_count);
    step();
    chk("load3_done_pulse", 16'(load_done), 16'd0);
    do_fetch(4'd0, 8'h53, "l3_pc0");
    do_fetch(4'd1, 8'hC1, "l3_pc1");
    do_fetch(4'd2, 8'hF1, "l3_pc2");
    do_fetch(4'd3, 8'h00, "l3_pc3");

    // Seventeen bytes offered; the 17th must be refused, no wrap to address 0.
    load_en = 1'b1;
    step();
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_data = 8'h10 + 8'(i);
      chk($sformatf("l17_ready_%0d", i), 16'(load_ready), (i < 16) ? 16'd1 : 16'd0);
      step();
    end
    chk("l17_ready_after", 16'(load_ready), 16'd0);
    chk("l17_still_busy", 16'(busy), 16'd1);
    chk("l17_no_done_yet", 16'(load_done), 16'd0);
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    chk("l17_done", 16'(load_done), 16'd1);
    chk("l17_count", 16'(load_count), 16'd16);
    $display("full session: done=%0d count=%0d", load_done, load_count);
    step();
    do_fetch(4'd15, 8'h1F, "l17_pc15");
    do_fetch(4'd0, 8'h10, "l17_pc0");

    // fetch_req and load_en together: load wins.
    pc_in     = 4'd3;
    fetch_req = 1'b1;
    load_en   = 1'b1;
    step();
    chk("tie_busy", 16'(busy), 16'd1);
    chk("tie_ferr", 16'(fetch_err), 16'd1);
    chk("tie_valid", 16'(instr_valid), 16'd0);
    chk("tie_instr_hold", 16'(instr_out), 16'h10);
    chk("tie_ready", 16'(load_ready), 16'd1);
    $display("fetch+load tie: busy=%0d fetch_err=%0d", busy, fetch_err);
    fetch_req = 1'b0;

    // Two bytes then reset: session aborted, memory cleared again.
    load_valid = 1'b1;
    load_data = 8'hAA; step();
    load_data = 8'hBB; step();
    load_valid = 1'b0;
    #1;
    rst_ctrl = 1'b1;
    #1;
    chk("abort_done", 16'(load_done), 16'd0);
    chk("abort_count", 16'(load_count), 16'd0);
    chk("abort_busy", 16'(busy), 16'd1);
    chk("abort_instr", 16'(instr_out), 16'h00);
    load_en = 1'b0;
    step();
    rst_ctrl = 1'b0;
    clear_wait();
    chk("abort_no_done", 16'(load_done), 16'd0);
    do_fetch(4'd0, 8'h00, "abort_pc0");
    do_fetch(4'd1, 8'h00, "abort_pc1");

`ifdef PROG_MEM_FETCH_CHECKSUM_EN
    load_en = 1'b1;
    step();
    chk("csum_zeroed", 16'(load_csum), 16'h00);
    load_valid = 1'b1;
    load_data = 8'hFF; step();
    load_data = 8'h02; step();
    load_data = 8'h10; step();
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    chk("csum_done", 16'(load_done), 16'd1);
    chk("csum_value", 16'(load_csum), 16'h11);
    $display("checksum session: csum=%h count=%0d", load_csum, load_count);
    step();
    chk("csum_stable", 16'(load_csum), 16'h11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
